// File: rtl/add_share_arbiter.sv
// add_share_arbiter: NREQ requesters share a single 32-bit Brent-Kung adder.
// A round-robin arbiter grants one request in IDLE, the operands are registered,
// the adder result is registered in EXEC, and the result is held in RESP until the
// consumer accepts it.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid[NREQ]   per-requester request
//   req_ready[NREQ]   per-requester accept (one-hot or zero, IDLE only)
//   req_a, req_b      packed operands, requester i in bits [32i+31:32i]
//   req_cin[NREQ]     per-requester carry-in
//   rsp_valid         result available (RESP state)
//   rsp_ready         consumer accepts result
//   rsp_sum[33]       {carry-out, sum}
//   rsp_id[IDW]       owner of rsp_sum
//   busy              high outside IDLE
//   op_count[16]      completed responses, saturating

// 32-bit Brent-Kung parallel-prefix adder with carry-in.
module bk_adder_32b (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [32:0] sum
);

   logic [31:0] g;
   logic [31:0] p;
   logic [31:0] p0;

   always_comb begin
      p0 = a ^ b;
      g  = a & b;
      p  = p0;
      // Fold carry-in into bit 0 so g[i] becomes the carry out of bit i.
      g[0] = g[0] | (p0[0] & cin);
      p[0] = 1'b0;
      // Up-sweep: build group (g,p) over aligned power-of-two spans.
      for (int l = 0; l < 5; l++) begin
         for (int i = 0; i < 32; i++) begin
            if (((i + 1) % (2 << l)) == 0) begin
               g[i] = g[i] | (p[i] & g[i - (1 << l)]);
               p[i] = p[i] & p[i - (1 << l)];
            end
         end
      end
      // Down-sweep: fill in the remaining prefixes from completed neighbours.
      for (int l = 3; l >= 0; l--) begin
         for (int i = 0; i < 32; i++) begin
            if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= (2 << l))) begin
               g[i] = g[i] | (p[i] & g[i - (1 << l)]);
               p[i] = p[i] & p[i - (1 << l)];
            end
         end
      end
      sum[0] = p0[0] ^ cin;
      for (int i = 1; i < 32; i++) begin
         sum[i] = p0[i] ^ g[i - 1];
      end
      sum[32] = g[31];
   end

endmodule

module add_share_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*32-1:0] req_a,
   input  logic [NREQ*32-1:0] req_b,
   input  logic [NREQ-1:0]    req_cin,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [32:0]        rsp_sum,
   output logic [IDW-1:0]     rsp_id,
   output logic               busy,
   output logic [15:0]        op_count
);

   localparam int NR = int'(NREQ);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e         state_q, state_d;
   logic [IDW-1:0] rr_ptr_q;
   logic [31:0]    op_a_q, op_b_q;
   logic           op_cin_q;
   logic [IDW-1:0] op_id_q;
   logic [32:0]    rsp_sum_q;
   logic [IDW-1:0] rsp_id_q;
   logic [15:0]    op_count_q;

   logic           grant_found;
   logic [IDW-1:0] grant_id;
   logic [IDW-1:0] next_ptr;
   logic           xfer;
   logic [32:0]    add_sum;

   bk_adder_32b u_adder (
      .a   (op_a_q),
      .b   (op_b_q),
      .cin (op_cin_q),
      .sum (add_sum)
   );

   // Round-robin search from rr_ptr; scanning offsets downward lets the
   // smallest offset with a valid request win.
   always_comb begin
      int idx;
      grant_found = 1'b0;
      grant_id    = '0;
      for (int k = NR - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr_q) + k) % NR;
         if (req_valid[idx[IDW-1:0]]) begin
            grant_found = 1'b1;
            grant_id    = idx[IDW-1:0];
         end
      end
   end

   assign next_ptr = (grant_id == IDW'(NR - 1)) ? '0 : grant_id + 1'b1;
   assign xfer     = (state_q == StIdle) && grant_found;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (xfer) state_d = StExec;
         StExec:  state_d = StResp;
         StResp:  if (rsp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs; req_ready is gated by rst_n so it is low for the whole reset.
   always_comb begin
      req_ready = '0;
      if (xfer && rst_n) begin
         req_ready[grant_id] = 1'b1;
      end
      rsp_valid = (state_q == StResp);
      busy      = (state_q != StIdle);
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q   <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         op_cin_q   <= 1'b0;
         op_id_q    <= '0;
         rsp_sum_q  <= '0;
         rsp_id_q   <= '0;
         op_count_q <= '0;
      end else begin
         if (xfer) begin
            op_a_q   <= req_a[{grant_id, 5'd0} +: 32];
            op_b_q   <= req_b[{grant_id, 5'd0} +: 32];
            op_cin_q <= req_cin[grant_id];
            op_id_q  <= grant_id;
            rr_ptr_q <= next_ptr;
         end
         if (state_q == StExec) begin
            rsp_sum_q <= add_sum;
            rsp_id_q  <= op_id_q;
         end
         if ((state_q == StResp) && rsp_ready && (op_count_q != 16'hFFFF)) begin
            op_count_q <= op_count_q + 16'd1;
         end
      end
   end

   assign rsp_sum  = rsp_sum_q;
   assign rsp_id   = rsp_id_q;
   assign op_count = op_count_q;

endmodule

// File: tb/tb_add_share_arbiter.sv
// Scoreboard bench for add_share_arbiter: stimulus predicts grants from the
// round-robin rule and pushes expected results; a monitor checks responses.
module tb_add_share_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*32-1:0] req_a;
   logic [NREQ*32-1:0] req_b;
   logic [NREQ-1:0]    req_cin;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [32:0]        rsp_sum;
   logic [IDW-1:0]     rsp_id;
   logic               busy;
   logic [15:0]        op_count;

   always #5 clk = ~clk;

   add_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_id    (rsp_id),
      .busy      (busy),
      .op_count  (op_count)
   );

   typedef struct {
      int          id;
      logic [32:0] sum;
      int          t;
   } exp_t;

   exp_t sb[$];

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Requester-side model state
   logic [NREQ-1:0] v_m = '0;
   logic [31:0]     a_m[NREQ];
   logic [31:0]     b_m[NREQ];
   logic [NREQ-1:0] c_m = '0;
   logic            rr_m = 1'b1;
   int              ptr_m = 0;
   bit              busy_m = 1'b0;
   logic [15:0]     cnt_m = '0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // First valid requester at or after ptr, wrapping; -1 when none.
   function automatic int pick(logic [NREQ-1:0] v, int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic set_req(int i, logic [31:0] a, logic [31:0] b, logic c);
      v_m[i] = 1'b1;
      a_m[i] = a;
      b_m[i] = b;
      c_m[i] = c;
   endtask

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 7))
         0:       return 32'hFFFF_FFFF;
         1:       return 32'h0;
         default: return $urandom;
      endcase
   endfunction

   task automatic cycle();
      int              g;
      logic [NREQ-1:0] exp_rdy;
      @(negedge clk);
      req_valid = v_m;
      req_cin   = c_m;
      rsp_ready = rr_m;
      for (int i = 0; i < NREQ; i++) begin
         req_a[32*i +: 32] = a_m[i];
         req_b[32*i +: 32] = b_m[i];
      end
      #1;
      if (rst_n) begin
         g       = busy_m ? -1 : pick(v_m, ptr_m);
         exp_rdy = '0;
         if (g >= 0) exp_rdy[g] = 1'b1;
         chk("req_ready", 64'(req_ready), 64'(exp_rdy));
         chk("busy", 64'(busy), 64'(busy_m));
         if (g >= 0) begin
            sb.push_back('{g, {1'b0, a_m[g]} + {1'b0, b_m[g]} + 33'(c_m[g]), cyc});
            busy_m = 1'b1;
            ptr_m  = (g + 1) % NREQ;
            v_m[g] = 1'b0;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_op_count", 64'(op_count), 64'd0);
      chk("rst_rsp_sum", 64'(rsp_sum), 64'd0);
      chk("rst_rsp_id", 64'(rsp_id), 64'd0);
      sb.delete();
      busy_m    = 1'b0;
      ptr_m     = 0;
      cnt_m     = '0;
      req_valid = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain();
      v_m  = '0;
      rr_m = 1'b1;
      for (int k = 0; k < 20 && (sb.size() > 0 || busy_m); k++) cycle();
      chk("drain_pending", 64'(sb.size()), 64'd0);
   endtask

   // Response monitor
   initial begin
      bit ev;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            ev = (sb.size() > 0) && ((cyc - sb[0].t) >= 2);
            chk("rsp_valid", 64'(rsp_valid), 64'(ev));
            chk("op_count", 64'(op_count), 64'(cnt_m));
            if (rsp_valid && sb.size() > 0) begin
               chk("rsp_sum", 64'(rsp_sum), 64'(sb[0].sum));
               chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
            end
            if (rsp_valid && rsp_ready && ev) begin
               void'(sb.pop_front());
               busy_m = 1'b0;
               if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         a_m[i] = '0;
         b_m[i] = '0;
      end
      rst_n     = 1'b0;
      req_valid = '1;
      req_a     = '0;
      req_b     = '0;
      req_cin   = '0;
      rsp_ready = 1'b1;
      #1;
      chk("init_req_ready", 64'(req_ready), 64'd0);
      chk("init_busy", 64'(busy), 64'd0);
      chk("init_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("init_op_count", 64'(op_count), 64'd0);
      chk("init_rsp_sum", 64'(rsp_sum), 64'd0);
      req_valid = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Single op with carry-out, then carry-in on requester 2
      set_req(0, 32'hFFFF_FFFF, 32'h1, 1'b0);
      repeat (5) cycle();
      set_req(2, 32'h5, 32'hA, 1'b1);
      repeat (5) cycle();

      // Reset during EXEC discards the op; next grant is lowest valid index
      set_req(2, 32'h1234, 32'h1, 1'b0);
      cycle();
      do_reset();
      set_req(1, 32'h10, 32'h20, 1'b0);
      set_req(3, 32'h30, 32'h40, 1'b1);
      drain_keep();
      drain();

      // Fairness: all requesters held valid
      do_reset();
      for (int k = 0; k < 16; k++) begin
         for (int i = 0; i < NREQ; i++) if (!v_m[i]) set_req(i, rnd_op(), rnd_op(), 1'($urandom));
         cycle();
      end
      drain();

      // Backpressure: response held with competing requests present
      set_req(1, 32'hDEAD_BEEF, 32'h2152_4111, 1'b1);
      rr_m = 1'b0;
      cycle();
      set_req(0, 32'h1, 32'h2, 1'b0);
      set_req(3, 32'h3, 32'h4, 1'b0);
      repeat (8) cycle();
      drain();

      // Randomized traffic with backpressure and request withdrawal
      for (int k = 0; k < 1500; k++) begin
         rr_m = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NREQ; i++) begin
            if (!v_m[i] && $urandom_range(0, 3) == 0) set_req(i, rnd_op(), rnd_op(), 1'($urandom));
            else if (v_m[i] && $urandom_range(0, 15) == 0) v_m[i] = 1'b0;
         end
         cycle();
      end
      drain();

      // Saturation: preload the counter near its limit
      cycle();
      @(negedge clk);
      force dut.op_count_q = 16'hFFFD;
      cnt_m = 16'hFFFD;
      #1;
      release dut.op_count_q;
      for (int k = 0; k < 4; k++) begin
         set_req(0, $urandom, $urandom, 1'b0);
         repeat (4) cycle();
      end
      drain();
      chk("sat_op_count", 64'(op_count), 64'hFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Runs a few cycles keeping current requests so they are granted in order.
   task automatic drain_keep();
      rr_m = 1'b1;
      repeat (8) cycle();
   endtask

endmodule
